tile_drawer: RTL and testbench

TILE_DRAWER -- requirements
Module: tile_drawer

---
 rtl/tile_drawer_if.sv | 23 ++
 rtl/tile_drawer.sv | 161 ++++++++++++++++
 tb/tb_tile_drawer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tile_drawer_if.sv
// Request/pixel bus between the board datapath, the tile drawer and the VGA adapter.
interface tile_drawer_if;
  logic       start;
  logic [7:0] x_plot;
  logic [6:0] y_plot;
  logic [1:0] select;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, x_plot, y_plot, select,
    input  vga_x, vga_y, colour, plot, busy, done
  );

  modport slave (
    input  start, x_plot, y_plot, select,
    output vga_x, vga_y, colour, plot, busy, done
  );
endinterface

// File: rtl/tile_drawer.sv
// Raster-scans one TILE x TILE board tile (empty, cursor box or disk) into VGA pixel writes.
// Optional macro TILE_DRAWER_GRID_EN draws grid lines on the right/bottom edges of empty tiles.
module tile_drawer #(
  parameter int unsigned TILE      = 12,
  parameter logic [2:0]  BG_COLOUR = 3'b010
) (
  input logic         clock,
  input logic         resetn,
  tile_drawer_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] ZERO    = CW'(0);
  localparam logic [CW-1:0] LAST    = CW'(TILE - 1);
  localparam logic [CW-1:0] DISK_LO = CW'(2);
  localparam logic [CW-1:0] DISK_HI = CW'(TILE - 3);

  localparam logic [2:0] C_CURSOR = 3'b110;
  localparam logic [2:0] C_SIDE0  = 3'b000;
  localparam logic [2:0] C_SIDE1  = 3'b111;
`ifdef TILE_DRAWER_GRID_EN
  localparam logic [2:0] C_GRID   = 3'b001;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] sel;
  } tile_req_t;

  // Returns {plot, colour} for one pixel of a tile of the given kind.
  function automatic logic [3:0] shade(input logic [1:0]    sel,
                                       input logic [CW-1:0] px,
                                       input logic [CW-1:0] py);
    logic       on_border;
    logic       in_sq;
    logic       sq_corner;
    logic [3:0] res;
`ifdef TILE_DRAWER_GRID_EN
    logic       on_last;
    on_last   = (px == LAST) || (py == LAST);
`endif
    on_border = (px == ZERO) || (px == LAST) || (py == ZERO) || (py == LAST);
    in_sq     = (px >= DISK_LO) && (px <= DISK_HI) && (py >= DISK_LO) && (py <= DISK_HI);
    sq_corner = ((px == DISK_LO) || (px == DISK_HI)) && ((py == DISK_LO) || (py == DISK_HI));
    res       = {1'b1, BG_COLOUR};
    case (sel)
      2'd0: begin
`ifdef TILE_DRAWER_GRID_EN
        if (on_last) res = {1'b1, C_GRID};
`endif
      end
      2'd1: res = on_border ? {1'b1, C_CURSOR} : 4'b0000;
      default: begin
        if (in_sq && !sq_corner) res = {1'b1, sel[0] ? C_SIDE1 : C_SIDE0};
      end
    endcase
    return res;
  endfunction

  logic [1:0]    state, state_nxt;
  tile_req_t     req, req_nxt;
  logic [CW-1:0] dx, dx_nxt;
  logic [CW-1:0] dy, dy_nxt;
  logic          draw_nxt;
  logic          done_nxt;
  logic [3:0]    pix;
  logic [7:0]    vga_x_q, vga_x_nxt;
  logic [6:0]    vga_y_q, vga_y_nxt;
  logic [2:0]    colour_q, colour_nxt;
  logic          plot_q, plot_nxt;
  logic          busy_q;
  logic          done_q;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state, pixel counters and the pixel that the outputs show next cycle.
  // dx/dy always track the pixel currently presented on the registered outputs.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    dx_nxt    = dx;
    dy_nxt    = dy;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_DRAW;
          req_nxt   = '{x: bus.x_plot, y: bus.y_plot, sel: bus.select};
          dx_nxt    = ZERO;
          dy_nxt    = ZERO;
        end
      end
      S_DRAW: begin
        if ((dx == LAST) && (dy == LAST)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (dx == LAST) begin
          dx_nxt = ZERO;
          dy_nxt = CW'(dy + CW'(1));
        end else begin
          dx_nxt = CW'(dx + CW'(1));
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    draw_nxt   = (state_nxt == S_DRAW);
    pix        = shade(req_nxt.sel, dx_nxt, dy_nxt);
    plot_nxt   = draw_nxt & pix[3];
    colour_nxt = draw_nxt ? pix[2:0] : 3'b000;
    vga_x_nxt  = vga_x_q;
    vga_y_nxt  = vga_y_q;
    if (draw_nxt) begin
      vga_x_nxt = 8'(req_nxt.x + 8'(dx_nxt));
      vga_y_nxt = 7'(req_nxt.y + 7'(dy_nxt));
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      req      <= '0;
      dx       <= ZERO;
      dy       <= ZERO;
      vga_x_q  <= 8'd0;
      vga_y_q  <= 7'd0;
      colour_q <= 3'b000;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      req      <= req_nxt;
      dx       <= dx_nxt;
      dy       <= dy_nxt;
      vga_x_q  <= vga_x_nxt;
      vga_y_q  <= vga_y_nxt;
      colour_q <= colour_nxt;
      plot_q   <= plot_nxt;
      busy_q   <= draw_nxt;
      done_q   <= done_nxt;
    end
  end

  assign bus.vga_x  = vga_x_q;
  assign bus.vga_y  = vga_y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_tile_drawer.sv
// Scoreboard bench for tile_drawer: stimulus pushes expected pixels/done pulses, a monitor checks them.
module tb_tile_drawer;
  localparam int TILE = 12;
  localparam int NPIX = TILE * TILE;
  localparam int BG   = 2;

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } pix_t;

  logic clock = 1'b0;
  logic resetn;
  tile_drawer_if bus();

  tile_drawer #(.TILE(TILE), .BG_COLOUR(3'b010)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  pix_t pq[$];
  int   dq[$];
  int   next_free = 0;
  int   act_a = 0;
  bit   have_act = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Colour of a tile pixel from the drawing rules; -1 means the pixel is not plotted.
  function automatic int exp_colour(int sel, int dx, int dy);
    bit border;
    bit disk;
    border = (dx == 0) || (dx == TILE - 1) || (dy == 0) || (dy == TILE - 1);
    disk   = (dx >= 2) && (dx <= TILE - 3) && (dy >= 2) && (dy <= TILE - 3) &&
             !(((dx == 2) || (dx == TILE - 3)) && ((dy == 2) || (dy == TILE - 3)));
    case (sel)
      0: begin
`ifdef TILE_DRAWER_GRID_EN
        if ((dx == TILE - 1) || (dy == TILE - 1)) return 1;
`endif
        return BG;
      end
      1: return border ? 6 : -1;
      2: return disk ? 0 : BG;
      default: return disk ? 7 : BG;
    endcase
  endfunction

  task automatic accept(input int e, input int x, input int y, input int sel);
    for (int idx = 0; idx < NPIX; idx++) begin
      int dx;
      int dy;
      int c;
      dx = idx % TILE;
      dy = idx / TILE;
      c  = exp_colour(sel, dx, dy);
      if (c >= 0) pq.push_back('{e + idx, (x + dx) % 256, (y + dy) % 128, c});
    end
    dq.push_back(e + NPIX);
    next_free = e + NPIX + 2;
    act_a     = e;
    have_act  = 1'b1;
  endtask

  // Called at posedge+1; drives inputs for the next edge and advances one cycle.
  task automatic drive(input logic st, input logic [7:0] x, input logic [6:0] y, input logic [1:0] s);
    int e;
    bus.start  = st;
    bus.x_plot = x;
    bus.y_plot = y;
    bus.select = s;
    e = cyc + 1;
    if (st && (e >= next_free)) accept(e, int'(x), int'(y), int'(s));
    @(posedge clock);
    #1;
  endtask

  task automatic junk();
    drive(1'($urandom), 8'($urandom), 7'($urandom), 2'($urandom));
  endtask

  task automatic tile(input logic [7:0] x, input logic [6:0] y, input logic [1:0] s);
    drive(1'b1, x, y, s);
    repeat (NPIX + 1) junk();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_plot"},   int'(bus.plot),   0);
    chk({tag, "_busy"},   int'(bus.busy),   0);
    chk({tag, "_done"},   int'(bus.done),   0);
    chk({tag, "_vga_x"},  int'(bus.vga_x),  0);
    chk({tag, "_vga_y"},  int'(bus.vga_y),  0);
    chk({tag, "_colour"}, int'(bus.colour), 0);
  endtask

  // Monitor: compares every cycle's outputs with the scoreboard.
  always @(negedge clock) begin
    if (mon_en) begin
      bit   ep;
      bit   ed;
      bit   eb;
      pix_t p;
      ep = (pq.size() > 0) && (pq[0].cyc == cyc);
      chk("plot", int'(bus.plot), int'(ep));
      if (ep) begin
        p = pq.pop_front();
        if (bus.plot) begin
          chk("vga_x",  int'(bus.vga_x),  p.x);
          chk("vga_y",  int'(bus.vga_y),  p.y);
          chk("colour", int'(bus.colour), p.col);
        end
      end
      ed = (dq.size() > 0) && (dq[0] == cyc);
      chk("done", int'(bus.done), int'(ed));
      if (ed) void'(dq.pop_front());
      eb = have_act && (cyc >= act_a) && (cyc < act_a + NPIX);
      chk("busy", int'(bus.busy), int'(eb));
    end
  end

  initial begin
    resetn     = 1'b0;
    bus.start  = 1'b0;
    bus.x_plot = 8'd0;
    bus.y_plot = 7'd0;
    bus.select = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    resetn = 1'b1;
    mon_en = 1'b1;

    tile(8'd9,   7'd9,   2'd0);
    tile(8'd22,  7'd9,   2'd1);
    tile(8'd9,   7'd22,  2'd3);
    tile(8'd250, 7'd40,  2'd0);
    tile(8'd100, 7'd125, 2'd2);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) drive(1'b0, 8'd0, 7'd0, 2'd0);
      tile(8'($urandom), 7'($urandom), 2'($urandom));
    end

    // Abort a tile part-way through with an asynchronous reset.
    drive(1'b1, 8'd30, 7'd30, 2'd3);
    repeat (50) junk();
    resetn = 1'b0;
    pq.delete();
    dq.delete();
    have_act  = 1'b0;
    next_free = 0;
    #1;
    check_zero("abort");
    @(posedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    tile(8'd60, 7'd60, 2'd1);

    repeat (NPIX + 4) drive(1'b0, 8'd0, 7'd0, 2'd0);
    chk("pending_pixels", pq.size(), 0);
    chk("pending_done",   dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
